// File: rtl/rpsc_pkg.sv
// Shared constants and types for the RPSC card 3 input/interlock modules.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rpsc_pkg;

   localparam int RPSC_N_CH     = 16;
   localparam int RPSC_TICK_DIV = 500;
   localparam int RPSC_FILT_CNT = 8;

   typedef logic [$clog2(RPSC_N_CH)-1:0] ch_id_t;

   // Bits needed to hold the values 0..n-1, never less than one bit.
   function automatic int bits_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rpsc_debounce_ch.sv
// One channel: 2-flop synchroniser, tick-sampled debounce counter, filtered level.
// Latency: 2 clk sync + up to FILT_CNT sample ticks; filt changes the cycle after the accepting tick.
// Backpressure: none, free-running.
module rpsc_debounce_ch
   import rpsc_pkg::*;
#(
   parameter int FILT_CNT = RPSC_FILT_CNT
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   input  logic sample_tick,
   output logic filt
);

   localparam int               CNT_W    = bits_for(FILT_CNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

   logic             sync_meta;
   logic             sync;
   logic [CNT_W-1:0] cnt;

   // Bring the asynchronous input into the clk domain.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         sync_meta <= raw;
         sync      <= sync_meta;
      end
   end

   // Count consecutive disagreeing ticks; any agreeing tick restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         filt <= 1'b0;
      end else if (sample_tick) begin
         if (sync == filt) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            filt <= sync;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/rpsc_input_filter.sv
// Input conditioning for RPSC card 3: per-channel debounce, rise pulses, first-fault capture.
// Latency: filt_out = 2 clk + up to TICK_DIV + (FILT_CNT-1)*TICK_DIV; rise +1; first fault +1 more.
// Backpressure: none, free-running; fault_clr is a single-cycle pulse.
module rpsc_input_filter
   import rpsc_pkg::*;
#(
   parameter int              N_CH       = RPSC_N_CH,
   parameter int              TICK_DIV   = RPSC_TICK_DIV,
   parameter int              FILT_CNT   = RPSC_FILT_CNT,
   parameter logic [N_CH-1:0] FAULT_MASK = '1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_CH-1:0]         raw_in,
   input  logic                    fault_clr,
   output logic [N_CH-1:0]         filt_out,
   output logic [N_CH-1:0]         rise_pulse,
   output logic                    sample_tick,
   output logic                    settled,
   output logic                    first_fault_valid,
   output logic [$clog2(N_CH)-1:0] first_fault_id
);

   localparam int                ID_W      = $clog2(N_CH);
   localparam int                PCNT_W    = bits_for(TICK_DIV);
   localparam int                TCNT_W    = bits_for(FILT_CNT + 1);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);
   localparam logic [TCNT_W-1:0] TCNT_FULL = TCNT_W'(FILT_CNT);

   logic [PCNT_W-1:0] pcnt;
   logic [TCNT_W-1:0] tcnt;
   logic [N_CH-1:0]   filt_q;
   logic [N_CH-1:0]   masked_rise;
   logic [ID_W-1:0]   low_id;

   // Gated by reset so that a TICK_DIV of 1 still shows no tick while held in reset.
   assign sample_tick = ~reset & (pcnt == PCNT_LAST);
   assign settled     = (tcnt == TCNT_FULL);
   assign masked_rise = rise_pulse & FAULT_MASK;

   // Prescaler: wraps at TICK_DIV-1.
   always_ff @(posedge clk) begin
      if (reset || pcnt == PCNT_LAST) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + 1'b1;
      end
   end

   // Tick counter since reset, saturating at FILT_CNT.
   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt <= '0;
      end else if (sample_tick && tcnt != TCNT_FULL) begin
         tcnt <= tcnt + 1'b1;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      rpsc_debounce_ch #(
         .FILT_CNT (FILT_CNT)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .raw         (raw_in[g]),
         .sample_tick (sample_tick),
         .filt        (filt_out[g])
      );
   end

   // Registered 0->1 edge detect on the filtered levels.
   always_ff @(posedge clk) begin
      if (reset) begin
         filt_q     <= '0;
         rise_pulse <= '0;
      end else begin
         filt_q     <= filt_out;
         rise_pulse <= filt_out & ~filt_q;
      end
   end

   // Lowest-index eligible rise wins when several channels rise together.
   always_comb begin
      low_id = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (masked_rise[i]) begin
            low_id = ID_W'(i);
         end
      end
   end

   // First-fault record; a clear coinciding with a new rise still captures it.
   always_ff @(posedge clk) begin
      if (reset) begin
         first_fault_valid <= 1'b0;
         first_fault_id    <= '0;
      end else if ((!first_fault_valid || fault_clr) && (|masked_rise)) begin
         first_fault_valid <= 1'b1;
         first_fault_id    <= low_id;
      end else if (fault_clr) begin
         first_fault_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rpsc_input_filter.sv
// Bench for rpsc_input_filter: directed cycle-exact checks, then random stimulus vs a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rpsc_input_filter;
   import rpsc_pkg::*;

   localparam int          N    = 16;
   localparam int          TD   = 4;
   localparam int          FC   = 3;
   localparam logic [N-1:0] MASK = 16'hFFEF;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] raw_in;
   logic         fault_clr;
   logic [N-1:0] filt_out;
   logic [N-1:0] rise_pulse;
   logic         sample_tick;
   logic         settled;
   logic         first_fault_valid;
   ch_id_t       first_fault_id;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   rpsc_input_filter #(
      .N_CH       (N),
      .TICK_DIV   (TD),
      .FILT_CNT   (FC),
      .FAULT_MASK (MASK)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .raw_in            (raw_in),
      .fault_clr         (fault_clr),
      .filt_out          (filt_out),
      .rise_pulse        (rise_pulse),
      .sample_tick       (sample_tick),
      .settled           (settled),
      .first_fault_valid (first_fault_valid),
      .first_fault_id    (first_fault_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // State holds the values that the outputs show during the current cycle.
   logic [N-1:0] m_pipe1 = '0, m_pipe2 = '0;   // raw delayed by one and two cycles
   logic [N-1:0] m_filt = '0, m_filt_prev = '0, m_rise = '0;
   int           m_disagree[N];                // consecutive ticks where sampled input differs from level
   int           m_cyc = 0;                    // cycles since reset release
   int           m_ticks = 0;
   logic         m_ffv = 1'b0;
   ch_id_t       m_ffid = '0;

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return 0;
   endfunction

   initial for (int i = 0; i < N; i++) m_disagree[i] = 0;

   always @(posedge clk) begin
      logic         tick;
      logic [N-1:0] eligible;
      logic [N-1:0] next_rise;
      if (reset) begin
         m_pipe1 = '0; m_pipe2 = '0; m_filt = '0; m_filt_prev = '0; m_rise = '0;
         for (int i = 0; i < N; i++) m_disagree[i] = 0;
         m_cyc = 0; m_ticks = 0; m_ffv = 1'b0; m_ffid = '0;
      end else begin
         tick     = ((m_cyc % TD) == TD - 1);
         eligible = m_rise & MASK;
         if ((!m_ffv || fault_clr) && eligible != '0) begin
            m_ffv  = 1'b1;
            m_ffid = ch_id_t'(lowest(eligible));
         end else if (fault_clr) begin
            m_ffv = 1'b0;
         end
         next_rise   = m_filt & ~m_filt_prev;
         m_filt_prev = m_filt;
         m_rise      = next_rise;
         if (tick) begin
            for (int i = 0; i < N; i++) begin
               if (m_pipe2[i] == m_filt[i]) begin
                  m_disagree[i] = 0;
               end else begin
                  m_disagree[i] = m_disagree[i] + 1;
                  if (m_disagree[i] >= FC) begin
                     m_filt[i]     = m_pipe2[i];
                     m_disagree[i] = 0;
                  end
               end
            end
            if (m_ticks < FC) m_ticks = m_ticks + 1;
         end
         m_pipe2 = m_pipe1;
         m_pipe1 = raw_in;
         m_cyc   = m_cyc + 1;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      #1;
      if (chk_en) begin
         chk("m_filt_out",   filt_out,          m_filt);
         chk("m_rise_pulse", rise_pulse,        m_rise);
         chk("m_tick",       sample_tick,       !reset && ((m_cyc % TD) == TD - 1));
         chk("m_settled",    settled,           m_ticks >= FC);
         chk("m_ff_valid",   first_fault_valid, m_ffv);
         chk("m_ff_id",      first_fault_id,    m_ffid);
      end
   end

   // Wait (at negedges) until the model's cycle index reaches c.
   task automatic at_cycle(input int c);
      int guard = 0;
      while (m_cyc != c) begin
         @(negedge clk);
         guard++;
         if (guard > 2000) begin
            errors++;
            $display("FAIL at_cycle_timeout: got cycle %0d expected %0d", m_cyc, c);
            return;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks);
      $fatal(1);
   end

   // ---------------- directed then random stimulus ----------------
   initial begin
      reset = 1'b1; raw_in = '0; fault_clr = 1'b0;
      @(posedge clk);
      chk_en = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_filt", filt_out, 0);
      chk("rst_rise", rise_pulse, 0);
      chk("rst_tick", sample_tick, 0);
      chk("rst_settled", settled, 0);
      chk("rst_ffv", first_fault_valid, 0);
      chk("rst_ffid", first_fault_id, 0);
      reset = 1'b0; raw_in[5] = 1'b1;               // cycle 0

      at_cycle(2);  chk("tick_c2", sample_tick, 0);
      at_cycle(3);  chk("tick_c3", sample_tick, 1);
      at_cycle(11); chk("filt5_c11", filt_out[5], 0); chk("settled_c11", settled, 0);
      at_cycle(12); chk("filt5_c12", filt_out[5], 1); chk("settled_c12", settled, 1);
      at_cycle(13); chk("rise_c13", rise_pulse, 16'h0020);
      at_cycle(14); chk("rise_c14", rise_pulse, 0);
      chk("ffv_c14", first_fault_valid, 1); chk("ffid_c14", first_fault_id, 5);

      // glitch of two ticks is rejected, a three-tick pulse is accepted both ways
      at_cycle(20); raw_in[2] = 1'b1;
      at_cycle(26); raw_in[2] = 1'b0;
      at_cycle(40); chk("glitch_filt2", filt_out[2], 0); raw_in[2] = 1'b1;
      at_cycle(51); chk("pulse_filt2_c51", filt_out[2], 0);
      at_cycle(52); chk("pulse_filt2_c52", filt_out[2], 1); raw_in[2] = 1'b0;
      at_cycle(53); chk("pulse_rise_c53", rise_pulse, 16'h0004);
      at_cycle(63); chk("fall_filt2_c63", filt_out[2], 1);
      at_cycle(64); chk("fall_filt2_c64", filt_out[2], 0);

      // clear alone, then simultaneous rise on 3 and 9
      at_cycle(70); fault_clr = 1'b1;
      at_cycle(71); fault_clr = 1'b0; chk("clr_ffv", first_fault_valid, 0);
      at_cycle(72); raw_in[3] = 1'b1; raw_in[9] = 1'b1;
      at_cycle(83); chk("sim_filt_c83", filt_out & 16'h0208, 0);
      at_cycle(84); chk("sim_filt_c84", filt_out & 16'h0208, 16'h0208);
      at_cycle(85); chk("sim_rise_c85", rise_pulse, 16'h0208);
      at_cycle(86); chk("sim_ffv", first_fault_valid, 1); chk("sim_ffid", first_fault_id, 3);
      at_cycle(88); raw_in[7] = 1'b1;
      at_cycle(100); chk("ch7_filt", filt_out[7], 1);
      at_cycle(101); chk("ch7_rise", rise_pulse, 16'h0080);
      at_cycle(102); chk("ch7_ffid_kept", first_fault_id, 3); chk("ch7_ffv", first_fault_valid, 1);

      // clear coinciding with a rise on 11 captures it
      at_cycle(104); raw_in[11] = 1'b1;
      at_cycle(117); chk("ch11_rise", rise_pulse, 16'h0800); fault_clr = 1'b1;
      at_cycle(118); fault_clr = 1'b0;
      chk("clr_rise_ffv", first_fault_valid, 1); chk("clr_rise_ffid", first_fault_id, 11);

      // masked channel 4 never captured
      at_cycle(120); fault_clr = 1'b1;
      at_cycle(121); fault_clr = 1'b0; chk("clr2_ffv", first_fault_valid, 0);
      at_cycle(122); raw_in[4] = 1'b1;
      at_cycle(136); chk("ch4_filt", filt_out[4], 1);
      at_cycle(137); chk("ch4_rise", rise_pulse, 16'h0010);
      at_cycle(138); chk("ch4_masked_ffv", first_fault_valid, 0);

      // reset part-way through a count on channel 0
      at_cycle(144); raw_in[0] = 1'b1;
      at_cycle(152); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      chk("rst2_filt", filt_out, 0); chk("rst2_ffv", first_fault_valid, 0);
      chk("rst2_settled", settled, 0);
      at_cycle(11); chk("rst2_filt0_c11", filt_out[0], 0);
      at_cycle(12); chk("rst2_filt_c12", filt_out, 16'h0AB9);
      at_cycle(13); chk("rst2_rise_c13", rise_pulse, 16'h0AB9);
      at_cycle(14); chk("rst2_ffv", first_fault_valid, 1); chk("rst2_ffid", first_fault_id, 0);

      // random phase, checked by the model every cycle
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(15) == 0) raw_in[i] = ~raw_in[i];
         end
         fault_clr = ($urandom_range(19) == 0);
         reset     = ($urandom_range(599) == 0);
      end
      @(negedge clk);
      reset = 1'b0; fault_clr = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
